// File: rtl/drc_pkg.sv
// rtl/drc_pkg.sv - shared state/mode encodings and helpers for the camera capture controller
package drc_pkg;

    typedef enum logic [2:0] {
        ST_SLEEP       = 3'd0,
        ST_IDLE        = 3'd1,
        ST_ALIGN       = 3'd2,
        ST_CAPTURE     = 3'd3,
        ST_ERR_CORRECT = 3'd4
    } drc_state_e;

    typedef enum logic [1:0] {
        MODE_SLEEP  = 2'd0,
        MODE_SINGLE = 2'd1,
        MODE_STREAM = 2'd2,
        MODE_BURST  = 2'd3
    } drc_mode_e;

    // Width of the per-pixel byte index; at least one bit even for 1-byte pixels.
    function automatic int byte_cnt_w(input int bytes_per_pxl);
        return (bytes_per_pxl > 1) ? $clog2(bytes_per_pxl) : 1;
    endfunction

    // Only single and burst captures acknowledge the software start request.
    function automatic logic mode_acks_start(input logic [1:0] mode);
        return (mode == MODE_SINGLE) || (mode == MODE_BURST);
    endfunction

endpackage

// File: rtl/drc_dim_counter.sv
// rtl/drc_dim_counter.sv - byte/width/height position counters with wrap and zero flags
module drc_dim_counter
    import drc_pkg::*;
#(
    parameter int BYTES_PER_PXL = 2,
    parameter int IMG_DIM_W     = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr_i,
    input  logic                 adv_i,
    input  logic [IMG_DIM_W-1:0] img_width_i,
    input  logic [IMG_DIM_W-1:0] img_height_i,
    output logic                 byte_zero_o,
    output logic                 width_zero_o,
    output logic                 height_zero_o,
    output logic                 byte_wrap_o,
    output logic                 width_wrap_o,
    output logic                 height_wrap_o
);

    localparam int BYTE_W = byte_cnt_w(BYTES_PER_PXL);
    localparam logic [BYTE_W-1:0]    BYTE_LAST = BYTE_W'(BYTES_PER_PXL - 1);
    localparam logic [IMG_DIM_W-1:0] DIM_ONE   = IMG_DIM_W'(1);

    logic [BYTE_W-1:0]    byte_q;
    logic [IMG_DIM_W-1:0] width_q;
    logic [IMG_DIM_W-1:0] height_q;
    logic [IMG_DIM_W-1:0] img_w_q;
    logic [IMG_DIM_W-1:0] img_h_q;

    assign byte_zero_o   = (byte_q == '0);
    assign width_zero_o  = (width_q == '0);
    assign height_zero_o = (height_q == '0);
    assign byte_wrap_o   = (byte_q == BYTE_LAST);
    assign width_wrap_o  = (width_q == img_w_q - DIM_ONE);
    assign height_wrap_o = (height_q == img_h_q - DIM_ONE);

    // Image dimensions are frozen on clear so mid-frame register writes cannot skew framing.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            byte_q   <= '0;
            width_q  <= '0;
            height_q <= '0;
            img_w_q  <= '0;
            img_h_q  <= '0;
        end else if (clr_i) begin
            byte_q   <= '0;
            width_q  <= '0;
            height_q <= '0;
            img_w_q  <= img_width_i;
            img_h_q  <= img_height_i;
        end else if (adv_i) begin
            if (byte_wrap_o) begin
                byte_q <= '0;
                if (width_wrap_o) begin
                    width_q  <= '0;
                    height_q <= height_wrap_o ? '0 : height_q + DIM_ONE;
                end else begin
                    width_q <= width_q + DIM_ONE;
                end
            end else begin
                byte_q <= byte_q + BYTE_W'(1);
            end
        end
    end

endmodule

// File: rtl/drc_cs_capture_ctrl.sv
// rtl/drc_cs_capture_ctrl.sv - DVP byte-stream capture FSM with sync checking and frame accounting
module drc_cs_capture_ctrl
    import drc_pkg::*;
#(
    parameter int DVP_DATA_W    = 8,
    parameter int BYTES_PER_PXL = 2,
    parameter int IMG_DIM_MAX   = 640,
    parameter int IMG_DIM_W     = $clog2(IMG_DIM_MAX),
    parameter int CNT_W         = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [DVP_DATA_W+1:0]  bwd_pxl_info_dat,
    input  logic                   bwd_pxl_info_vld,
    output logic                   bwd_pxl_info_rdy,
    output logic [DVP_DATA_W-1:0]  fwd_bpxl_dat,
    output logic                   fwd_bpxl_vld,
    input  logic                   fwd_bpxl_rdy,
    output logic                   fwd_bpxl_eol,
    output logic                   fwd_bpxl_last,
    input  logic                   cam_rx_en,
    input  logic                   cam_rx_start,
    input  logic [1:0]             cam_rx_mode,
    input  logic [CNT_W-1:0]       cam_rx_frm_num,
    output logic                   cam_rx_start_qed,
    output logic [2:0]             cam_rx_state,
    output logic [2*IMG_DIM_W-1:0] cam_rx_len,
    output logic [CNT_W-1:0]       cam_rx_frm_cnt,
    output logic [CNT_W-1:0]       cam_rx_err_cnt,
    input  logic [IMG_DIM_W-1:0]   img_width,
    input  logic [IMG_DIM_W-1:0]   img_height,
    input  logic                   irq_msk_frm_comp,
    input  logic                   irq_msk_frm_err,
    output logic                   irq,
    output logic                   trap
);

    localparam int LEN_W = 2 * IMG_DIM_W;

    drc_state_e       state_q;
    logic [CNT_W-1:0] frm_cnt_q;
    logic [CNT_W-1:0] err_cnt_q;
    logic [LEN_W-1:0] len_q;
    logic             irq_q;
    logic             trap_q;
    logic             start_qed_q;

    logic                  in_vsync;
    logic                  in_hsync;
    logic [DVP_DATA_W-1:0] in_byte;
    logic byte_zero, width_zero, height_zero;
    logic byte_wrap, width_wrap, height_wrap;
    logic adv, clr_dims, pred_hsync, pred_vsync, sync_err, burst_more;

    assign in_vsync = bwd_pxl_info_dat[DVP_DATA_W+1];
    assign in_hsync = bwd_pxl_info_dat[DVP_DATA_W];
    assign in_byte  = bwd_pxl_info_dat[DVP_DATA_W-1:0];

    always_comb begin
        bwd_pxl_info_rdy = 1'b0;
        fwd_bpxl_vld     = 1'b0;
        fwd_bpxl_dat     = '0;
        case (state_q)
            ST_SLEEP:       bwd_pxl_info_rdy = 1'b1;
            ST_ALIGN:       bwd_pxl_info_rdy = !(bwd_pxl_info_vld && in_vsync);
            ST_CAPTURE: begin
                fwd_bpxl_vld     = bwd_pxl_info_vld;
                bwd_pxl_info_rdy = fwd_bpxl_rdy;
                fwd_bpxl_dat     = in_byte;
            end
            // Pad the rest of a corrupted frame with zeros so the DMA stays frame-aligned.
            ST_ERR_CORRECT: begin
                bwd_pxl_info_rdy = 1'b1;
                fwd_bpxl_vld     = 1'b1;
            end
            default: ;
        endcase
    end

    assign adv           = fwd_bpxl_vld && fwd_bpxl_rdy;
    assign clr_dims      = (state_q == ST_ALIGN) && bwd_pxl_info_vld && in_vsync;
    assign fwd_bpxl_eol  = fwd_bpxl_vld && byte_wrap && width_wrap;
    assign fwd_bpxl_last = fwd_bpxl_eol && height_wrap;
    assign pred_hsync    = width_zero && byte_zero;
    assign pred_vsync    = pred_hsync && height_zero;
    assign sync_err      = (state_q == ST_CAPTURE) && adv &&
                           ((in_hsync != pred_hsync) || (in_vsync != pred_vsync));
    // A zero burst length degenerates to a single frame.
    assign burst_more    = (cam_rx_mode == MODE_BURST) && (cam_rx_frm_num != '0) &&
                           (frm_cnt_q != cam_rx_frm_num);

    drc_dim_counter #(
        .BYTES_PER_PXL (BYTES_PER_PXL),
        .IMG_DIM_W     (IMG_DIM_W)
    ) u_dim_counter (
        .clk           (clk),
        .rst           (rst),
        .clr_i         (clr_dims),
        .adv_i         (adv),
        .img_width_i   (img_width),
        .img_height_i  (img_height),
        .byte_zero_o   (byte_zero),
        .width_zero_o  (width_zero),
        .height_zero_o (height_zero),
        .byte_wrap_o   (byte_wrap),
        .width_wrap_o  (width_wrap),
        .height_wrap_o (height_wrap)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_SLEEP;
            frm_cnt_q   <= '0;
            err_cnt_q   <= '0;
            len_q       <= '0;
            irq_q       <= 1'b0;
            trap_q      <= 1'b0;
            start_qed_q <= 1'b0;
        end else begin
            irq_q       <= 1'b0;
            trap_q      <= 1'b0;
            start_qed_q <= 1'b0;
            if (adv && byte_wrap) begin
                len_q <= len_q + LEN_W'(1);
            end
            case (state_q)
                ST_SLEEP: begin
                    if (cam_rx_en && cam_rx_start && (cam_rx_mode != MODE_SLEEP)) begin
                        state_q     <= ST_ALIGN;
                        frm_cnt_q   <= '0;
                        err_cnt_q   <= '0;
                        len_q       <= '0;
                        start_qed_q <= mode_acks_start(cam_rx_mode);
                    end
                end
                ST_IDLE: begin
                    if (cam_rx_en && ((cam_rx_mode == MODE_STREAM) || burst_more)) begin
                        state_q <= ST_ALIGN;
                        len_q   <= '0;
                    end else if (cam_rx_en && cam_rx_start && (cam_rx_mode == MODE_SINGLE)) begin
                        state_q     <= ST_ALIGN;
                        len_q       <= '0;
                        start_qed_q <= 1'b1;
                    end else begin
                        state_q <= ST_SLEEP;
                    end
                end
                ST_ALIGN: begin
                    if (clr_dims) begin
                        state_q <= ST_CAPTURE;
                    end
                end
                ST_CAPTURE: begin
                    if (sync_err) begin
                        trap_q <= irq_msk_frm_err;
                        if (err_cnt_q != '1) begin
                            err_cnt_q <= err_cnt_q + CNT_W'(1);
                        end
                        // A bad final byte leaves nothing to pad; resynchronise directly.
                        if (fwd_bpxl_last) begin
                            state_q <= ST_ALIGN;
                            len_q   <= '0;
                        end else begin
                            state_q <= ST_ERR_CORRECT;
                        end
                    end else if (adv && fwd_bpxl_last) begin
                        state_q   <= ST_IDLE;
                        frm_cnt_q <= frm_cnt_q + CNT_W'(1);
                        irq_q     <= irq_msk_frm_comp;
                    end
                end
                ST_ERR_CORRECT: begin
                    if (adv && fwd_bpxl_last) begin
                        state_q <= ST_ALIGN;
                        len_q   <= '0;
                    end
                end
                default: state_q <= ST_SLEEP;
            endcase
        end
    end

    assign cam_rx_state     = state_q;
    assign cam_rx_len       = len_q;
    assign cam_rx_frm_cnt   = frm_cnt_q;
    assign cam_rx_err_cnt   = err_cnt_q;
    assign cam_rx_start_qed = start_qed_q;
    assign irq              = irq_q;
    assign trap             = trap_q;

endmodule

// File: tb/tb_drc_cs_capture_ctrl.sv
// tb/tb_drc_cs_capture_ctrl.sv - scoreboard bench: 2-byte pixels on a 4x2 image across all capture modes
module tb_drc_cs_capture_ctrl;

    localparam int DW = 8;
    localparam int DIMW = 10;
    localparam int CW = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic [DW+1:0]   bwd_dat;
    logic            bwd_vld;
    logic            bwd_rdy;
    logic [DW-1:0]   fwd_dat;
    logic            fwd_vld;
    logic            fwd_rdy;
    logic            fwd_eol;
    logic            fwd_last;
    logic            cam_rx_en;
    logic            cam_rx_start;
    logic [1:0]      cam_rx_mode;
    logic [CW-1:0]   cam_rx_frm_num;
    logic            start_qed;
    logic [2:0]      state;
    logic [2*DIMW-1:0] rx_len;
    logic [CW-1:0]   frm_cnt;
    logic [CW-1:0]   err_cnt;
    logic [DIMW-1:0] img_width;
    logic [DIMW-1:0] img_height;
    logic            msk_comp;
    logic            msk_err;
    logic            irq;
    logic            trap;

    always #5 clk = ~clk;

    drc_cs_capture_ctrl #(
        .DVP_DATA_W (DW), .BYTES_PER_PXL (2), .IMG_DIM_MAX (640), .IMG_DIM_W (DIMW), .CNT_W (CW)
    ) dut (
        .clk (clk), .rst (rst),
        .bwd_pxl_info_dat (bwd_dat), .bwd_pxl_info_vld (bwd_vld), .bwd_pxl_info_rdy (bwd_rdy),
        .fwd_bpxl_dat (fwd_dat), .fwd_bpxl_vld (fwd_vld), .fwd_bpxl_rdy (fwd_rdy),
        .fwd_bpxl_eol (fwd_eol), .fwd_bpxl_last (fwd_last),
        .cam_rx_en (cam_rx_en), .cam_rx_start (cam_rx_start), .cam_rx_mode (cam_rx_mode),
        .cam_rx_frm_num (cam_rx_frm_num), .cam_rx_start_qed (start_qed), .cam_rx_state (state),
        .cam_rx_len (rx_len), .cam_rx_frm_cnt (frm_cnt), .cam_rx_err_cnt (err_cnt),
        .img_width (img_width), .img_height (img_height),
        .irq_msk_frm_comp (msk_comp), .irq_msk_frm_err (msk_err), .irq (irq), .trap (trap)
    );

    typedef struct packed {
        logic [DW-1:0] d;
        logic          eol;
        logic          last;
    } beat_t;

    beat_t sb[$];
    beat_t exp_beat;
    int total = 0;
    int bad = 0;
    int irq_seen = 0;
    int trap_seen = 0;
    int sq_seen = 0;
    int i0, t0, s0;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string nm);
        total++;
        bad++;
        $display("FAIL %s (t=%0t)", nm, $time);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (irq) irq_seen++;
            if (trap) trap_seen++;
            if (start_qed) sq_seen++;
            if (fwd_vld && fwd_rdy) begin
                if (sb.size() == 0) begin
                    fail_now("unexpected_beat");
                end else begin
                    exp_beat = sb.pop_front();
                    chk("beat_dat", fwd_dat, exp_beat.d);
                    chk("beat_eol", fwd_eol, exp_beat.eol);
                    chk("beat_last", fwd_last, exp_beat.last);
                end
            end
        end
    end

    task automatic send_byte(input logic vs, input logic hs, input logic [DW-1:0] b);
        int n;
        bwd_vld = 1'b1;
        bwd_dat = {vs, hs, b};
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bwd_rdy && n < 100);
        if (!bwd_rdy) fail_now("send_byte_timeout");
        @(posedge clk);
        #1;
        bwd_vld = 1'b0;
    endtask

    // One 4x2 frame of 16 bytes; err_at flips hsync on that byte, stall_at holds fwd_rdy low,
    // drop_at clears cam_rx_en, stop_at abandons the frame before that byte.
    task automatic send_frame(input int base, input int err_at, input int stall_at,
                              input int drop_at, input int stop_at);
        int p, bb, w, h;
        logic eol, hs;
        for (int i = 0; i < 16; i++) begin
            p = i / 2; bb = i % 2; w = p % 4; h = p / 4;
            eol = (bb == 1) && (w == 3);
            sb.push_back('{d: (err_at >= 0 && i > err_at) ? 8'h00 : DW'(base + i),
                           eol: eol, last: eol && (h == 1)});
        end
        for (int i = 0; i < 16; i++) begin
            if ((err_at >= 0 && i > err_at) || i == stop_at) break;
            p = i / 2; bb = i % 2; w = p % 4;
            hs = (w == 0) && (bb == 0);
            if (i == err_at) hs = !hs;
            if (i == drop_at) cam_rx_en = 1'b0;
            if (i == stall_at) begin
                fwd_rdy = 1'b0;
                bwd_vld = 1'b1;
                bwd_dat = {1'b0, hs, DW'(base + i)};
                repeat (5) begin
                    @(negedge clk);
                    chk("stall_bwd_rdy", bwd_rdy, 0);
                end
                @(posedge clk);
                #1;
                fwd_rdy = 1'b1;
            end
            send_byte(i == 0, hs, DW'(base + i));
        end
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (sb.size() != 0) fail_now("drain_timeout");
    endtask

    task automatic do_start(input logic [1:0] m);
        cam_rx_mode = m;
        cam_rx_en = 1'b1;
        cam_rx_start = 1'b1;
        @(posedge clk);
        #1;
        cam_rx_start = 1'b0;
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        bwd_dat = '0; bwd_vld = 1'b0; fwd_rdy = 1'b1;
        cam_rx_en = 1'b0; cam_rx_start = 1'b0; cam_rx_mode = 2'd0; cam_rx_frm_num = '0;
        img_width = 10'd4; img_height = 10'd2; msk_comp = 1'b1; msk_err = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_state", state, 0);
        chk("rst_bwd_rdy", bwd_rdy, 1);
        chk("rst_fwd_vld", fwd_vld, 0);
        chk("rst_irq", irq, 0);
        chk("rst_trap", trap, 0);
        chk("rst_start_qed", start_qed, 0);
        chk("rst_len", rx_len, 0);
        chk("rst_frm_cnt", frm_cnt, 0);
        chk("rst_err_cnt", err_cnt, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // single clean frame
        do_start(2'd1);
        send_frame(8'h10, -1, -1, -1, -1);
        chk("single_state_idle", state, 1);
        chk("single_irq", irq, 1);
        chk("single_len", rx_len, 8);
        chk("single_frm_cnt", frm_cnt, 1);
        chk("single_sb_empty", sb.size(), 0);
        @(posedge clk);
        #1;
        chk("single_state_sleep", state, 0);
        chk("single_irq_pulses", irq_seen, 1);
        chk("single_start_qed", sq_seen, 1);

        // missing hsync on byte 9
        i0 = irq_seen; t0 = trap_seen;
        do_start(2'd1);
        send_frame(8'h40, 8, -1, -1, -1);
        wait_drain();
        chk("err_state_align", state, 2);
        chk("err_err_cnt", err_cnt, 1);
        chk("err_frm_cnt", frm_cnt, 0);
        chk("err_trap_pulses", trap_seen - t0, 1);
        chk("err_no_irq", irq_seen - i0, 0);
        pulse_rst();

        // burst of three
        i0 = irq_seen; s0 = sq_seen;
        cam_rx_frm_num = 8'd3;
        do_start(2'd3);
        send_frame(8'h80, -1, -1, -1, -1);
        send_frame(8'h90, -1, -1, -1, -1);
        send_frame(8'hA0, -1, -1, -1, -1);
        chk("burst_frm_cnt", frm_cnt, 3);
        chk("burst_state_idle", state, 1);
        @(posedge clk);
        #1;
        chk("burst_state_sleep", state, 0);
        chk("burst_irq_pulses", irq_seen - i0, 3);
        chk("burst_start_qed", sq_seen - s0, 1);

        // stream, enable dropped during frame 2
        i0 = irq_seen; s0 = sq_seen;
        do_start(2'd2);
        send_frame(8'h20, -1, -1, -1, -1);
        send_frame(8'h30, -1, -1, 5, -1);
        chk("stream_state_idle", state, 1);
        chk("stream_frm_cnt", frm_cnt, 2);
        @(posedge clk);
        #1;
        chk("stream_state_sleep", state, 0);
        chk("stream_irq_pulses", irq_seen - i0, 2);
        chk("stream_no_start_qed", sq_seen - s0, 0);

        // downstream stall mid-row
        do_start(2'd1);
        send_frame(8'h50, -1, 5, -1, -1);
        chk("stall_len", rx_len, 8);
        chk("stall_state_idle", state, 1);
        chk("stall_sb_empty", sb.size(), 0);
        @(posedge clk);
        #1;

        // reset in the middle of capture
        do_start(2'd1);
        send_frame(8'h60, -1, -1, -1, 5);
        chk("midrst_state_capture", state, 3);
        chk("midrst_len_before", rx_len, 2);
        sb.delete();
        bwd_vld = 1'b1;
        bwd_dat = {2'b00, 8'h65};
        #1;
        chk("midrst_fwd_vld_before", fwd_vld, 1);
        chk("midrst_fwd_dat_before", fwd_dat, 8'h65);
        rst = 1'b1;
        #1;
        chk("midrst_state", state, 0);
        chk("midrst_fwd_vld", fwd_vld, 0);
        chk("midrst_len", rx_len, 0);
        chk("midrst_frm_cnt", frm_cnt, 0);
        chk("midrst_err_cnt", err_cnt, 0);
        chk("midrst_bwd_rdy", bwd_rdy, 1);
        bwd_vld = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("final_sb_empty", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/drc_cs_capture_ctrl.md
DRC_CS_CAPTURE_CTRL -- requirements
Module: drc_cs_capture_ctrl

Interface
REQ-001 SHALL have parameter DVP_DATA_W, default 8, DVP byte width.
REQ-002 SHALL have parameter BYTES_PER_PXL, default 2, legal 1..4, DVP bytes per pixel.
REQ-003 SHALL have parameter IMG_DIM_MAX, default 640, maximum image width/height.
REQ-004 SHALL have parameter IMG_DIM_W, default $clog2(IMG_DIM_MAX), dimension counter width.
REQ-005 SHALL have parameter CNT_W, default 8, frame/error counter width.
REQ-006 SHALL have clk  in  1  sole clock, rising edge.
REQ-007 SHALL have rst  in  1  asynchronous, active-high reset.
REQ-008 SHALL have bwd_pxl_info_dat/vld/rdy  in/in/out  DVP_DATA_W+2/1/1  {vsync,hsync,byte} from pixel FIFO.
REQ-009 SHALL have fwd_bpxl_dat/vld/rdy  out/out/in  DVP_DATA_W/1/1  byte stream to DMA.
REQ-010 SHALL have fwd_bpxl_eol, fwd_bpxl_last  out  1 each  last byte of row / of frame.
REQ-011 SHALL have cam_rx_en, cam_rx_start  in  1 each; cam_rx_mode  in  2  (0 sleep, 1 single, 2 stream, 3 burst); cam_rx_frm_num  in  CNT_W  burst length.
REQ-012 SHALL have cam_rx_start_qed  out  1; cam_rx_state  out  3; cam_rx_len  out  2*IMG_DIM_W; cam_rx_frm_cnt, cam_rx_err_cnt  out  CNT_W each.
REQ-013 SHALL have img_width, img_height  in  IMG_DIM_W each; irq_msk_frm_comp, irq_msk_frm_err  in  1 each; irq, trap  out  1 each.

Function
REQ-014 States SHALL be SLEEP=0, IDLE=1, ALIGN=2, CAPTURE=3, ERR_CORRECT=4; cam_rx_state = registered state.
REQ-015 SLEEP: rdy=1 (discard); on en & start & mode!=0 -> ALIGN, clear frm_cnt and err_cnt; start_qed=1 for one cycle in modes 1 and 3 only.
REQ-016 ALIGN: rdy=1 until vld & vsync, then rdy=0 that cycle, clear byte/width/height/pixel counters, -> CAPTURE.
REQ-017 CAPTURE: fwd_vld = bwd_vld, bwd_rdy = fwd_rdy, fwd_dat = byte, zero added latency (combinational pass-through).
REQ-018 Byte counter SHALL wrap at BYTES_PER_PXL-1; on wrap width increments, wrapping at img_width-1; on width wrap height increments, wrapping at img_height-1.
REQ-019 Predicted hsync = (width==0 & byte==0); predicted vsync = (width==0 & height==0 & byte==0).
REQ-020 On handshake, hsync or vsync differing from prediction -> ERR_CORRECT, err_cnt +1 saturating at all-ones, trap = irq_msk_frm_err for one cycle.
REQ-021 fwd_bpxl_eol = byte wrap & width wrap; fwd_bpxl_last = eol & height wrap; both combinational, valid only with fwd_vld.
REQ-022 Handshake on last byte without error -> IDLE, frm_cnt +1 (wrapping), irq = irq_msk_frm_comp for one cycle.
REQ-023 cam_rx_len = registered count of completed pixels in current frame; cleared in ALIGN entry; holds final value in IDLE/SLEEP.
REQ-024 IDLE (one cycle): mode 2 & en -> ALIGN; mode 3 & en & frm_cnt != frm_num -> ALIGN; mode 1 & en & start -> ALIGN with start_qed=1; otherwise -> SLEEP.
REQ-025 ERR_CORRECT: bwd_rdy=1, fwd_vld=1, fwd_dat=0; counters advance per forward handshake; eol/last valid; on last byte -> ALIGN (frame not counted, no irq).
REQ-026 cam_rx_en deassert or mode change during CAPTURE/ERR_CORRECT SHALL NOT abort; checked only in IDLE.
REQ-027 Burst with frm_num=0 SHALL behave as single frame.
REQ-028 img_width/img_height SHALL be sampled only at ALIGN exit; changes mid-frame ignored.

Reset
REQ-029 rst SHALL force SLEEP and zero all counters immediately, mid-frame included.
REQ-030 During/after reset: irq=0, trap=0, start_qed=0, fwd_vld=0, cam_rx_len=0, frm_cnt=0, err_cnt=0, bwd_rdy=1 (SLEEP).

Structure
REQ-031 State encodings, mode encodings shall live in shared package drc_pkg.
REQ-032 One sub-module drc_dim_counter (byte/width/height counters with wrap flags).

Verification
REQ-033 BYTES_PER_PXL=2, 4x2 image, mode 1, clean frame -> 16 bytes forwarded, eol on bytes 8 and 16, last on 16, irq one cycle, cam_rx_len=8, state IDLE then SLEEP.
REQ-034 Same image, hsync missing on byte 9 -> trap one cycle, err_cnt=1, 7 zero bytes forwarded, last on 16th, -> ALIGN.
REQ-035 Mode 3, frm_num=3, three clean frames -> frm_cnt=3, three irq pulses, start_qed once, then SLEEP.
REQ-036 Mode 2, en dropped mid-frame 2 -> frame 2 completes, irq, then SLEEP.
REQ-037 fwd_rdy low 5 cycles mid-row -> bwd_rdy low, no byte lost or duplicated.
REQ-038 rst pulse mid-CAPTURE -> state 0, all counters 0, fwd_vld=0 same cycle.
